// File: rtl/sys_bus_router_if.sv
// Core data-port bus seen by the router: request fields from the core,
// read data, read strobe and stall back to the core.
interface sys_bus_router_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  en;
    logic                  rdwr;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   mask;
    logic [DATA_W-1:0]     rd_data;
    logic                  rvalid;
    logic                  stall;

    modport master (
        output en, rdwr, addr, wr_data, mask,
        input  rd_data, rvalid, stall
    );

    modport slave (
        input  en, rdwr, addr, wr_data, mask,
        output rd_data, rvalid, stall
    );
endinterface

// File: rtl/sys_bus_router.sv
// System-bus router: decodes the region selector into a one-hot slave enable,
// tracks per-slave fixed read latency and records unmapped accesses.
module sys_bus_router #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SEL_HI     = 31,
    parameter int SEL_LO     = 28,
    parameter logic [NUM_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_SEL = {4'h3, 4'h2, 4'h9, 4'h0},
    parameter logic [NUM_SLAVES*4-1:0]                 RD_LAT    = {4'd1, 4'd1, 4'd2, 4'd1},
    parameter logic [DATA_W-1:0]                       ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    sys_bus_router_if.slave              m,
    output logic [NUM_SLAVES-1:0]        s_en,
    output logic                         s_rdwr,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wr_data,
    output logic [DATA_W/8-1:0]          s_mask,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
    output logic                         err,
    output logic [ADDR_W-1:0]            err_addr,
    input  logic                         err_clr
);

    localparam int SW    = SEL_HI - SEL_LO + 1;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_n;
    logic [3:0]         cnt_q, cnt_n;
    logic [IDX_W-1:0]   sel_q, sel_n;
    logic               unmap_q, unmap_n;
    logic               err_n;
    logic [ADDR_W-1:0]  err_addr_n;

    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;
    logic [3:0]         hit_lat;
    logic               accept;

    // A programmed latency of 0 behaves as a single-cycle slave.
    function automatic logic [3:0] lat_of(input int idx);
        logic [3:0] l;
        l = RD_LAT[idx*4 +: 4];
        return (l == 4'd0) ? 4'd1 : l;
    endfunction

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        hit_lat = 4'd1;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (m.addr[SEL_HI:SEL_LO] == SLAVE_SEL[i*SW +: SW]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
                hit_lat = lat_of(i);
            end
        end
    end

    assign m.stall  = (state_q == WAIT);
    assign m.rvalid = (state_q == RESP);
    // rst gates acceptance so no slave sees an enable while reset is asserted.
    assign accept   = rst && m.en && !m.stall;

    always_comb begin
        s_en = '0;
        if (accept && hit_any) s_en[hit_idx] = 1'b1;
    end

    assign s_rdwr    = m.rdwr;
    assign s_addr    = {m.addr[ADDR_W-1:2], 2'b00};
    assign s_wr_data = m.wr_data;
    assign s_mask    = m.mask;

    always_comb begin
        m.rd_data = '0;
        if (state_q == RESP) begin
            m.rd_data = unmap_q ? ERR_RDATA : s_rd_data[int'(sel_q)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        sel_n      = sel_q;
        unmap_n    = unmap_q;
        err_n      = err;
        err_addr_n = err_addr;

        case (state_q)
            WAIT: begin
                cnt_n = cnt_q - 4'd1;
                if (cnt_n == 4'd1) state_n = RESP;
            end
            default: begin
                // IDLE and RESP both accept; a new read in RESP reloads the tracker.
                state_n = IDLE;
                if (accept && !m.rdwr) begin
                    cnt_n   = hit_any ? hit_lat : 4'd1;
                    sel_n   = hit_idx;
                    unmap_n = !hit_any;
                    state_n = (cnt_n == 4'd1) ? RESP : WAIT;
                end
            end
        endcase

        if (err_clr) err_n = 1'b0;
        if (accept && !hit_any) begin
            err_n      = 1'b1;
            err_addr_n = m.addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            unmap_q  <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            sel_q    <= sel_n;
            unmap_q  <= unmap_n;
            err      <= err_n;
            err_addr <= err_addr_n;
        end
    end

endmodule

// File: tb/tb_sys_bus_router.sv
// Bench for sys_bus_router: directed scenarios plus randomized traffic
// checked against a cycle-indexed transaction model.
module tb_sys_bus_router;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sys_bus_router_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [NS-1:0]    s_en;
    logic             s_rdwr;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wr_data;
    logic [DW/8-1:0]  s_mask;
    logic [NS*DW-1:0] s_rd_data;
    logic             err;
    logic [AW-1:0]    err_addr;
    logic             err_clr;

    sys_bus_router #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .m(bus),
        .s_en(s_en), .s_rdwr(s_rdwr), .s_addr(s_addr), .s_wr_data(s_wr_data),
        .s_mask(s_mask), .s_rd_data(s_rd_data),
        .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    // Reference model: region codes and latencies per slave index.
    int codes[NS] = '{0, 9, 2, 3};
    int lats[NS]  = '{1, 2, 1, 1};
    bit          pend;
    int          resp_at;
    int          rsel;
    int          cyc;
    bit          m_err;
    logic [31:0] m_err_addr;

    logic        exp_stall, exp_rvalid, exp_acc;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sen;
    int          exp_idx;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] slice(input int i);
        return s_rd_data[i*32 +: 32];
    endfunction

    // Drive one cycle's inputs, then at the falling edge compute what the model expects.
    task automatic settle(input logic en, input logic rdwr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] mask, input logic clr);
        #1;
        bus.en = en; bus.rdwr = rdwr; bus.addr = addr; bus.wr_data = wd; bus.mask = mask;
        err_clr = clr;
        s_rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        exp_stall  = pend && (cyc < resp_at);
        exp_rvalid = pend && (cyc == resp_at);
        exp_acc    = en && !exp_stall;
        exp_idx    = -1;
        for (int i = 0; i < NS; i++)
            if (exp_idx < 0 && addr[31:28] == 4'(codes[i])) exp_idx = i;
        exp_sen   = (exp_acc && exp_idx >= 0) ? 4'(1 << exp_idx) : 4'b0;
        exp_rdata = !exp_rvalid ? 32'h0 : (rsel < 0 ? 32'hDEAD_BEEF : slice(rsel));
    endtask

    // Clock edge: commit the transaction the model accepted this cycle.
    task automatic advance();
        @(posedge clk);
        if (pend && cyc == resp_at) pend = 1'b0;
        if (exp_acc && !bus.rdwr) begin
            pend    = 1'b1;
            resp_at = cyc + ((exp_idx < 0) ? 1 : lats[exp_idx]);
            rsel    = exp_idx;
        end
        if (err_clr) m_err = 1'b0;
        if (exp_acc && exp_idx < 0) begin
            m_err      = 1'b1;
            m_err_addr = bus.addr;
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.en = 1'b1; bus.rdwr = 1'b0; bus.addr = 32'h0; bus.wr_data = '0; bus.mask = '0;
        err_clr = 1'b0; s_rd_data = '0;
        pend = 0; resp_at = 0; rsel = 0; cyc = 0; m_err = 0; m_err_addr = '0;
        #3;
        n_checks++; if (s_en !== 4'b0) $display("FAIL reset_sen got %b exp 0000", s_en); else n_pass++;
        n_checks++; if (bus.stall !== 1'b0 || bus.rvalid !== 1'b0)
            $display("FAIL reset_strobes stall=%b rvalid=%b exp 0/0", bus.stall, bus.rvalid); else n_pass++;
        n_checks++; if (bus.rd_data !== 32'h0) $display("FAIL reset_rdata got %h exp 0", bus.rd_data); else n_pass++;
        n_checks++; if (err !== 1'b0 || err_addr !== 32'h0)
            $display("FAIL reset_err err=%b addr=%h exp 0/0", err, err_addr); else n_pass++;
        bus.en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_write();
        settle(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0);
        n_checks++; if (s_en !== 4'b0001) $display("FAIL write_sen got %b exp 0001", s_en); else n_pass++;
        n_checks++; if (s_addr !== 32'h10) $display("FAIL write_saddr got %h exp 00000010", s_addr); else n_pass++;
        n_checks++; if (s_rdwr !== 1'b1 || s_wr_data !== 32'h1234_5678 || s_mask !== 4'hF)
            $display("FAIL write_bcast rdwr=%b data=%h mask=%h exp 1/12345678/f", s_rdwr, s_wr_data, s_mask); else n_pass++;
        n_checks++; if (bus.stall !== 1'b0) $display("FAIL write_stall got %b exp 0", bus.stall); else n_pass++;
        advance();
        settle(1'b0, 1'b0, 32'h0000_0013, 32'h0, 4'h0, 1'b0);
        n_checks++; if (s_en !== 4'b0 || bus.rvalid !== 1'b0)
            $display("FAIL write_after sen=%b rvalid=%b exp 0000/0", s_en, bus.rvalid); else n_pass++;
        n_checks++; if (s_addr !== 32'h10) $display("FAIL saddr_align got %h exp 00000010", s_addr); else n_pass++;
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[4] = '{32'h0, 32'h4, 32'h8, 32'h0};
        for (int k = 0; k < 4; k++) begin
            settle(k < 3, 1'b0, addrs[k], 32'h0, 4'h0, 1'b0);
            n_checks++; if (bus.stall !== 1'b0) $display("FAIL b2b_stall k=%0d got %b exp 0", k, bus.stall); else n_pass++;
            n_checks++; if (bus.rvalid !== (k > 0))
                $display("FAIL b2b_rvalid k=%0d got %b exp %b", k, bus.rvalid, k > 0); else n_pass++;
            n_checks++; if (bus.rd_data !== ((k > 0) ? slice(0) : 32'h0))
                $display("FAIL b2b_rdata k=%0d got %h exp %h", k, bus.rd_data, (k > 0) ? slice(0) : 32'h0); else n_pass++;
            advance();
        end
    endtask

    task automatic test_latency2();
        settle(1'b1, 1'b0, 32'h9000_0008, 32'h0, 4'h0, 1'b0);
        n_checks++; if (s_en !== 4'b0010) $display("FAIL lat2_sen got %b exp 0010", s_en); else n_pass++;
        n_checks++; if (bus.stall !== 1'b0) $display("FAIL lat2_c0_stall got %b exp 0", bus.stall); else n_pass++;
        advance();
        settle(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0);
        n_checks++; if (bus.stall !== 1'b1) $display("FAIL lat2_c1_stall got %b exp 1", bus.stall); else n_pass++;
        n_checks++; if (s_en !== 4'b0 || bus.rvalid !== 1'b0)
            $display("FAIL lat2_ignored sen=%b rvalid=%b exp 0000/0", s_en, bus.rvalid); else n_pass++;
        advance();
        settle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_checks++; if (bus.rvalid !== 1'b1 || bus.stall !== 1'b0)
            $display("FAIL lat2_c2 rvalid=%b stall=%b exp 1/0", bus.rvalid, bus.stall); else n_pass++;
        n_checks++; if (bus.rd_data !== slice(1)) $display("FAIL lat2_rdata got %h exp %h", bus.rd_data, slice(1)); else n_pass++;
        advance();
        settle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_checks++; if (bus.rvalid !== 1'b0) $display("FAIL lat2_c3_rvalid got %b exp 0", bus.rvalid); else n_pass++;
        advance();
    endtask

    task automatic test_unmapped();
        settle(1'b1, 1'b0, 32'h5000_0000, 32'h0, 4'h0, 1'b0);
        n_checks++; if (s_en !== 4'b0) $display("FAIL unm_sen got %b exp 0000", s_en); else n_pass++;
        advance();
        settle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_checks++; if (bus.rvalid !== 1'b1 || bus.rd_data !== 32'hDEAD_BEEF)
            $display("FAIL unm_rdata rvalid=%b data=%h exp 1/deadbeef", bus.rvalid, bus.rd_data); else n_pass++;
        n_checks++; if (err !== 1'b1 || err_addr !== 32'h5000_0000)
            $display("FAIL unm_err err=%b addr=%h exp 1/50000000", err, err_addr); else n_pass++;
        advance();
        settle(1'b1, 1'b1, 32'h6000_0004, 32'hAAAA_5555, 4'hF, 1'b1);
        n_checks++; if (s_en !== 4'b0) $display("FAIL unm_wr_sen got %b exp 0000", s_en); else n_pass++;
        advance();
        settle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        n_checks++; if (err !== 1'b1 || err_addr !== 32'h6000_0004)
            $display("FAIL clr_set_wins err=%b addr=%h exp 1/60000004", err, err_addr); else n_pass++;
        advance();
        settle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_checks++; if (err !== 1'b0 || err_addr !== 32'h6000_0004)
            $display("FAIL clr err=%b addr=%h exp 0/60000004", err, err_addr); else n_pass++;
        advance();
    endtask

    task automatic test_reset_midread();
        settle(1'b1, 1'b0, 32'h9000_0000, 32'h0, 4'h0, 1'b0);
        advance();
        settle(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0);
        n_checks++; if (bus.stall !== 1'b1) $display("FAIL rstmid_pre_stall got %b exp 1", bus.stall); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (bus.stall !== 1'b0 || bus.rvalid !== 1'b0 || s_en !== 4'b0)
            $display("FAIL rstmid_drop stall=%b rvalid=%b sen=%b exp 0/0/0000", bus.stall, bus.rvalid, s_en); else n_pass++;
        bus.en = 1'b0;
        pend = 0; m_err = 0; m_err_addr = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        settle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_checks++; if (bus.rvalid !== 1'b0 || bus.stall !== 1'b0)
            $display("FAIL rstmid_after rvalid=%b stall=%b exp 0/0", bus.rvalid, bus.stall); else n_pass++;
        advance();
        settle(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
        n_checks++; if (s_en !== 4'b0001) $display("FAIL rstmid_next_sen got %b exp 0001", s_en); else n_pass++;
        advance();
        settle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_checks++; if (bus.rvalid !== 1'b1 || bus.rd_data !== slice(0))
            $display("FAIL rstmid_next_rd rvalid=%b data=%h exp 1/%h", bus.rvalid, bus.rd_data, slice(0)); else n_pass++;
        advance();
    endtask

    task automatic test_random();
        logic [3:0] tops[6] = '{4'h0, 4'h9, 4'h2, 4'h3, 4'h5, 4'hF};
        logic [31:0] a;
        for (int k = 0; k < 300; k++) begin
            a = {tops[$urandom_range(0, 5)], 28'($urandom())};
            settle($urandom_range(0, 9) < 7, 1'($urandom()), a, $urandom(), 4'($urandom()),
                   $urandom_range(0, 9) == 0);
            n_checks++; if (bus.stall !== exp_stall)
                $display("FAIL rnd_stall k=%0d got %b exp %b", k, bus.stall, exp_stall); else n_pass++;
            n_checks++; if (bus.rvalid !== exp_rvalid)
                $display("FAIL rnd_rvalid k=%0d got %b exp %b", k, bus.rvalid, exp_rvalid); else n_pass++;
            n_checks++; if (bus.rd_data !== exp_rdata)
                $display("FAIL rnd_rdata k=%0d got %h exp %h", k, bus.rd_data, exp_rdata); else n_pass++;
            n_checks++; if (s_en !== exp_sen)
                $display("FAIL rnd_sen k=%0d got %b exp %b", k, s_en, exp_sen); else n_pass++;
            n_checks++; if (err !== m_err || err_addr !== m_err_addr)
                $display("FAIL rnd_err k=%0d got %b/%h exp %b/%h", k, err, err_addr, m_err, m_err_addr); else n_pass++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_latency2();
        test_unmapped();
        test_reset_midread();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
